// File: rtl/fetch_queue_ctrl.sv
// ---------------------------------------------------------------------------
// fetch_queue_ctrl
//
// Instruction fetch controller with a small prefetch queue. It sits between a
// combinational-read instruction memory and the decode stage.
//
// The block owns the fetch PC. Each cycle it fetches one word from the
// instruction memory. It stores that word together with its PC in a circular
// queue. Decode takes the head entry over a valid/ready handshake.
//
// A redirect flushes the queue and restarts fetch at a new PC. While halt is
// high, fetch is frozen but the queue keeps draining.
//
// Ports
//   clk             rising-edge clock
//   reset           asynchronous active-high reset
//   imem_addr       word address to instruction memory (fetch_pc[ADDR_WIDTH+1:2])
//   imem_rd         combinational read data for imem_addr
//   halt            level; suppresses new fetches while high
//   redirect_valid  one-cycle pulse: flush the queue, restart at redirect_pc
//   redirect_pc     new byte PC (low two bits ignored)
//   out_valid       head entry valid
//   out_ready       decode accepts the head entry
//   out_instr       head instruction
//   out_pc          head byte PC
//   count           number of occupied queue entries, 0..DEPTH
// ---------------------------------------------------------------------------
module fetch_queue_ctrl #(
    parameter int XLEN       = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int DEPTH      = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                      clk,
    input  logic                      reset,
    output logic [ADDR_WIDTH-1:0]     imem_addr,
    input  logic [XLEN-1:0]           imem_rd,
    input  logic                      halt,
    input  logic                      redirect_valid,
    input  logic [XLEN-1:0]           redirect_pc,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [XLEN-1:0]           out_instr,
    output logic [XLEN-1:0]           out_pc,
    output logic [$clog2(DEPTH):0]    count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } state_t;

    state_t            state_reg;
    state_t            state_next;
    logic [XLEN-1:0]   fetch_pc_reg;
    logic [PTR_W-1:0]  head_reg;
    logic [PTR_W-1:0]  tail_reg;
    logic [CNT_W-1:0]  count_reg;
    logic              push;
    logic              pop;

    logic [XLEN-1:0]   pc_mem    [DEPTH];
    logic [XLEN-1:0]   instr_mem [DEPTH];

    assign imem_addr = fetch_pc_reg[ADDR_WIDTH+1:2];
    assign count     = count_reg;
    assign out_valid = (count_reg != '0);
    assign out_instr = instr_mem[head_reg];
    assign out_pc    = pc_mem[head_reg];

    // Handshake and fetch qualification, plus the RUN/HALTED next-state logic.
    // A redirect voids any handshake in its cycle and blocks the push.
    // A full queue may still push when the head leaves in the same cycle.
    always_comb begin
        state_next = state_reg;
        pop        = 1'b0;
        push       = 1'b0;

        pop  = out_valid & out_ready & ~redirect_valid;
        push = (state_reg == RUN) & ~halt & ~redirect_valid
             & ((count_reg < CNT_W'(DEPTH)) | pop);

        case (state_reg)
            RUN:     if (halt)  state_next = HALTED;
            HALTED:  if (!halt) state_next = RUN;
            default: state_next = RUN;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= RUN;
        end else begin
            // The state always follows halt, even in a redirect cycle.
            state_reg <= state_next;
        end
    end

    // Pointers, occupancy and fetch PC.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc_reg <= RESET_PC;
            head_reg     <= '0;
            tail_reg     <= '0;
            count_reg    <= '0;
        end else if (redirect_valid) begin
            fetch_pc_reg <= redirect_pc & ~XLEN'(3);
            head_reg     <= '0;
            tail_reg     <= '0;
            count_reg    <= '0;
        end else begin
            if (push) begin
                tail_reg     <= tail_reg + 1'b1;      // power-of-two depth wraps naturally
                fetch_pc_reg <= fetch_pc_reg + XLEN'(4);
            end
            if (pop) begin
                head_reg <= head_reg + 1'b1;
            end
            count_reg <= count_reg + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Queue storage. It is a register per entry rather than a RAM, because
    // every entry must clear on reset and the head is read combinationally.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    pc_mem[gi]    <= '0;
                    instr_mem[gi] <= '0;
                end else if (push && (tail_reg == PTR_W'(gi))) begin
                    pc_mem[gi]    <= fetch_pc_reg;
                    instr_mem[gi] <= imem_rd;
                end
            end
        end
    endgenerate

endmodule

// File: doc/fetch_queue_ctrl.md
# fetch_queue_ctrl

Instruction fetch controller and prefetch queue sitting between the 256-word instruction memory and the decode stage. It owns the fetch PC and drives the memory's combinational word address every cycle. Each fetched word is captured with its PC into a small FIFO and handed to decode over a valid/ready handshake. Redirects from branch/jump resolution flush the queue and restart fetch; a halt input freezes fetch while the queue drains.

## Interface

Parameters:
- XLEN, 32, instruction and PC width
- ADDR_WIDTH, 8, instruction memory word-address width (2**ADDR_WIDTH words)
- DEPTH, 4, queue entries; power of two, ≥2
- RESET_PC, 0, byte PC loaded at reset; bits [1:0] must be 0

Ports:
- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- imem_addr  out  ADDR_WIDTH  word address to instruction memory = fetch_pc[ADDR_WIDTH+1:2]
- imem_rd  in  XLEN  combinational read data for imem_addr, same cycle
- halt  in  1  level; while high, no new fetches
- redirect_valid  in  1  one-cycle pulse; flush and restart at redirect_pc
- redirect_pc  in  XLEN  new byte PC; bits [1:0] ignored (forced 0)
- out_valid  out  1  head entry valid
- out_ready  in  1  decode accepts head
- out_instr  out  XLEN  head instruction
- out_pc  out  XLEN  head byte PC
- count  out  $clog2(DEPTH)+1  occupied entries, 0..DEPTH

## Operation

- State: fetch_pc (XLEN), circular buffer of DEPTH {pc, instr} entries, head/tail pointers, count. FSM states: RUN, HALTED.
- pop = out_valid & out_ready & ~redirect_valid.
- push = (state==RUN) & ~halt & ~redirect_valid & (count<DEPTH | pop).
- On push: entry[tail] ← {fetch_pc, imem_rd}; tail+1 mod DEPTH; fetch_pc ← fetch_pc+4 (wraps mod 2**XLEN). imem_addr therefore wraps word 2**ADDR_WIDTH-1 → 0 naturally.
- On pop: head+1 mod DEPTH.
- count ← count + push − pop; push and pop in the same cycle at count==DEPTH keep it at DEPTH; at count==0 pop cannot occur (out_valid=0).
- Redirect (highest priority): count←0, head←tail←0, fetch_pc←{redirect_pc[XLEN-1:2],2'b00}; no push; a handshake in that cycle is void (entry discarded, not consumed). Redirect overrides halt for the PC update; state follows halt.
- FSM: RUN→HALTED when halt=1 at edge; HALTED→RUN when halt=0. In HALTED no push; pops continue until empty; fetch_pc frozen.
- out_valid = (count≠0). out_instr/out_pc = entry[head]; contents don't-care when out_valid=0.

## Timing

- Reset values: fetch_pc=RESET_PC, imem_addr=RESET_PC[ADDR_WIDTH+1:2], count=0, out_valid=0, out_instr=0, out_pc=0, all entries 0, state=RUN.
- First instruction: the first rising edge after reset deasserts pushes RESET_PC; out_valid=1 in the following cycle (1-cycle fetch latency).
- Redirect latency: out_valid=0 in the cycle after the redirect edge; the first instruction at the new PC is valid one cycle later (2 cycles from the redirect pulse).
- Sustained throughput: 1 instruction/cycle with out_ready held high.
- Halt: takes effect at the first edge where it is sampled high; that edge does not push.
- Reset asserted mid-operation: state clears immediately (asynchronously) and in-flight entries are lost; no output is required to be stable during assertion other than reset values.

## Test plan

- Reset, then imem preloaded with word i = 0x1000_0000+i, out_ready=1 → out_pc 0,4,8,… with matching instr, one per cycle after a 1-cycle latency; count stays 1.
- out_ready=0 for 10 cycles → count saturates at 4 and fetch_pc stops at 0x10; raising out_ready yields pc 0x0,0x4,0x8,0xC,0x10 in order with no gap or duplicate.
- count=4 with out_ready=1 and no halt → simultaneous push/pop each cycle; count stays 4 and the PC sequence is contiguous.
- Redirect to 0x0000_0203 with 3 entries queued and out_ready=1 in the same cycle → that head is not consumed, count=0, and the next valid entry has pc 0x200 and instr = word 0x80.
- Redirect to 0x3F8 → pcs 0x3F8, 0x3FC, 0x400 with imem_addr 0xFE, 0xFF, 0x00 (address wrap).
- halt=1 with 4 queued → 4 pops then out_valid=0 and fetch_pc frozen; halt=0 resumes at the frozen PC. Async reset pulsed mid-stream → count=0 and out_valid=0 immediately, then restart at RESET_PC.
